ingredient_timer: RTL and testbench

//  Dispensing timer paired with the coffee-maker controller FSM.
//  - Consumes the FSM's start_timer pulse and ing_type code.
//  - Times the dispense interval selected by ing_type and returns t_expired to the FSM.
//  - Exposes busy/remaining seconds for the LED/display logic.

---
 rtl/ingredient_timer.sv | 143 ++++++++++++++
 tb/tb_ingredient_timer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ingredient_timer.sv
// ----------------------------------------------------------------------------
// ingredient_timer
//   Dispensing timer for the coffee-maker controller. A one-cycle start_timer
//   pulse loads the interval that ing_type selects. The interval then counts
//   down in whole seconds of CLK_DIV clocks each. When it reaches zero,
//   t_expired pulses for one cycle.
//
//   Optional feature macro: INGREDIENT_TIMER_PAUSE_EN
//     When this macro is defined, the block has a pause input. While pause is
//     high in RUN, the countdown is frozen.
//
// Ports
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   start_timer  in   1      load/start request, sampled every edge
//   ing_type     in   3      ingredient code, sampled with start_timer
//   pause        in   1      freeze countdown (INGREDIENT_TIMER_PAUSE_EN only)
//   t_expired    out  1      one-cycle pulse when the interval finishes
//   busy         out  1      high while counting (state RUN)
//   sec_left     out  SEC_W  seconds remaining, 0 when idle
//   ing_active   out  3      ing_type latched at the last accepted start
//
// Handshake: start_timer is a level. It is accepted on every edge where it is
//   high, and it always wins over any other transition, so a start during RUN
//   retriggers. t_expired is a state decode (DONE), so it is high for exactly
//   one cycle. The block has no ready or back-pressure signal.
// ----------------------------------------------------------------------------
module ingredient_timer #(
  parameter int CLK_DIV  = 50_000_000,
  parameter int PRESC_W  = 26,
  parameter int SEC_W    = 8,
  parameter int T_WATER  = 8,
  parameter int T_COFFEE = 4,
  parameter int T_MILK   = 5,
  parameter int T_CHOCO  = 4,
  parameter int T_SUGAR  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_timer,
  input  logic [2:0]       ing_type,
`ifdef INGREDIENT_TIMER_PAUSE_EN
  input  logic             pause,
`endif
  output logic             t_expired,
  output logic             busy,
  output logic [SEC_W-1:0] sec_left,
  output logic [2:0]       ing_active
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [SEC_W-1:0]   sec_q, sec_d;
  logic [2:0]         ing_q, ing_d;
  logic [SEC_W-1:0]   start_dur;
  logic               tick;
  logic               freeze;

  // Duration lookup. Unknown codes map to 0 s, and values are truncated to SEC_W.
  function automatic logic [SEC_W-1:0] dur(input logic [2:0] code);
    case (code)
      3'd1:    dur = SEC_W'(T_WATER);
      3'd2:    dur = SEC_W'(T_COFFEE);
      3'd3:    dur = SEC_W'(T_MILK);
      3'd4:    dur = SEC_W'(T_CHOCO);
      3'd5:    dur = SEC_W'(T_SUGAR);
      default: dur = '0;
    endcase
  endfunction

`ifdef INGREDIENT_TIMER_PAUSE_EN
  assign freeze = pause;
`else
  assign freeze = 1'b0;
`endif

  assign start_dur = dur(ing_type);
  assign tick      = (presc_q == PRESC_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      sec_q   <= '0;
      ing_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      ing_q   <= ing_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    sec_d   = sec_q;
    ing_d   = ing_q;
    if (start_timer) begin
      ing_d   = ing_type;
      presc_d = '0;
      sec_d   = start_dur;
      state_d = (start_dur == '0) ? S_DONE : S_RUN;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_RUN: begin
          if (!freeze) begin
            if (tick) begin
              presc_d = '0;
              // Treat 0 like 1 so sec_left can never wrap below zero.
              if (sec_q <= SEC_W'(1)) begin
                sec_d   = '0;
                state_d = S_DONE;
              end else begin
                sec_d = sec_q - SEC_W'(1);
              end
            end else begin
              presc_d = presc_q + PRESC_W'(1);
            end
          end
        end
        S_DONE: begin
          presc_d = '0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign t_expired  = (state_q == S_DONE);
  assign busy       = (state_q == S_RUN);
  assign sec_left   = sec_q;
  assign ing_active = ing_q;

endmodule

// File: tb/tb_ingredient_timer.sv
// ----------------------------------------------------------------------------
// tb_ingredient_timer
//   Directed bench for ingredient_timer with CLK_DIV=4, T_WATER=3, T_SUGAR=2.
//   When a start is issued, the stimulus pushes the expected t_expired event
//   into exp_q as {edge index, ing_active}. A monitor on the falling edge pops
//   one entry for every t_expired pulse it sees and compares the two.
// ----------------------------------------------------------------------------
module tb_ingredient_timer;

  localparam int CLK_DIV = 4;
  localparam int SEC_W   = 8;
  localparam int W       = 35;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start_timer = 1'b0;
  logic [2:0]       ing_type = 3'd0;
  logic             pause = 1'b0;
  logic             t_expired;
  logic             busy;
  logic [SEC_W-1:0] sec_left;
  logic [2:0]       ing_active;

  int               cyc = 0;
  int               vectors = 0;
  int               miscompares = 0;
  int               acc = 0;
  logic [W-1:0]     exp_q[$];

  ingredient_timer #(
    .CLK_DIV (CLK_DIV),
    .PRESC_W (3),
    .SEC_W   (SEC_W),
    .T_WATER (3),
    .T_SUGAR (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_timer (start_timer),
    .ing_type    (ing_type),
`ifdef INGREDIENT_TIMER_PAUSE_EN
    .pause       (pause),
`endif
    .t_expired   (t_expired),
    .busy        (busy),
    .sec_left    (sec_left),
    .ing_active  (ing_active)
  );

  // ---------------- clock / edge counter ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Move to 1 time unit after the n-th following rising edge.
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a one-cycle start. acc is set to the index of the accepting edge.
  task automatic do_start(input logic [2:0] code);
    @(negedge clk);
    start_timer = 1'b1;
    ing_type    = code;
    @(posedge clk);
    #1;
    acc         = cyc;
    start_timer = 1'b0;
  endtask

  task automatic expect_expiry(input int edge_idx, input logic [2:0] code);
    exp_q.push_back({edge_idx[31:0], code});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && t_expired) begin
      if (exp_q.size() == 0) begin
        check("unexpected_t_expired", 1, 0);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        check("t_expired_edge", cyc, e[W-1:3]);
        check("t_expired_ing", ing_active, e[2:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1. reset
    wait_edges(2);
    check("rst_busy", busy, 0);
    check("rst_sec_left", sec_left, 0);
    check("rst_t_expired", t_expired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(2);
    check("idle_busy", busy, 0);
    check("idle_sec_left", sec_left, 0);
    check("idle_ing_active", ing_active, 0);
    check("idle_t_expired", t_expired, 0);

    // 2. water: 3 s, expiry 12 edges after start
    do_start(3'd1);
    expect_expiry(acc + 12, 3'd1);
    check("water_busy", busy, 1);
    check("water_sec_3", sec_left, 3);
    check("water_ing", ing_active, 1);
    wait_edges(3);
    check("water_sec_3_late", sec_left, 3);
    wait_edges(1);
    check("water_sec_2", sec_left, 2);
    wait_edges(4);
    check("water_sec_1", sec_left, 1);
    check("water_busy_run", busy, 1);
    wait_edges(4);
    check("water_done_busy", busy, 0);
    check("water_done_sec", sec_left, 0);
    wait_edges(1);
    check("water_idle_busy", busy, 0);
    wait_drain("water_drain", 20);

    // 3. zero-duration codes: pulse right after the accepting edge
    do_start(3'd0);
    expect_expiry(acc, 3'd0);
    check("code0_busy", busy, 0);
    check("code0_sec", sec_left, 0);
    wait_edges(3);
    do_start(3'd7);
    expect_expiry(acc, 3'd7);
    check("code7_busy", busy, 0);
    wait_drain("zero_drain", 10);

    // 4. retrigger: water, then sugar when sec_left==2
    do_start(3'd1);
    wait_edges(4);
    check("retrig_pre_sec", sec_left, 2);
    do_start(3'd5);
    expect_expiry(acc + 8, 3'd5);
    check("retrig_sec", sec_left, 2);
    check("retrig_ing", ing_active, 5);
    check("retrig_busy", busy, 1);
    wait_drain("retrig_drain", 30);
    wait_edges(3);

    // 5. asynchronous reset mid-run: no pulse afterwards
    do_start(3'd1);
    wait_edges(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_sec", sec_left, 0);
    check("arst_ing", ing_active, 0);
    check("arst_t_expired", t_expired, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(20);
    check("arst_after_busy", busy, 0);

`ifdef INGREDIENT_TIMER_PAUSE_EN
    // 6. pause for 10 edges mid-run delays expiry by exactly 10
    do_start(3'd1);
    expect_expiry(acc + 12 + 10, 3'd1);
    wait_edges(5);
    @(negedge clk);
    pause = 1'b1;
    wait_edges(10);
    check("pause_sec", sec_left, 2);
    check("pause_busy", busy, 1);
    @(negedge clk);
    pause = 1'b0;
    wait_drain("pause_drain", 40);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
